// File: rtl/c2_display_scan_ctrl.sv
// c2_display_scan_ctrl: 4-digit seven-segment scan sequencer with a
// one-entry pending buffer committed to the converter at frame boundaries.
module c2_display_scan_ctrl #(
    parameter int DW       = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          blank,
    output logic [DW-1:0] disp_value,
    input  logic          sign,
    input  logic [DW-1:0] hundreds,
    input  logic [DW-1:0] tens,
    input  logic [DW-1:0] units,
    output logic [6:0]    seg_n,
    output logic [3:0]    an_n,
    output logic          frame_tick
);

    localparam int             PW     = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRE_TC = PW'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        DIG_U = 2'd0,
        DIG_T = 2'd1,
        DIG_H = 2'd2,
        DIG_S = 2'd3
    } dig_t;

    logic [PW-1:0] r_pre;
    dig_t          r_dig;
    dig_t          w_dig_nxt;
    logic          w_tc;
    logic          w_bound;
    logic [DW-1:0] r_pend;
    logic          r_pend_full;
    logic [DW-1:0] r_disp;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_tick;
    logic [6:0]    w_seg;
    logic [3:0]    w_an;
    logic          w_hz;
    logic          w_tz;

    // Digit glyph lookup; any value above 9 (full width) shows 'E'.
    function automatic logic [6:0] f_seg(input logic [DW-1:0] v);
        logic [6:0] s;
        s = SEG_E;
        if (v <= DW'(9)) begin
            case (v[3:0])
                4'd0:    s = 7'b1000000;
                4'd1:    s = 7'b1111001;
                4'd2:    s = 7'b0100100;
                4'd3:    s = 7'b0110000;
                4'd4:    s = 7'b0011001;
                4'd5:    s = 7'b0010010;
                4'd6:    s = 7'b0000010;
                4'd7:    s = 7'b1111000;
                4'd8:    s = 7'b0000000;
                4'd9:    s = 7'b0010000;
                default: s = SEG_E;
            endcase
        end
        return s;
    endfunction

    assign w_tc       = (r_pre == PRE_TC);
    assign w_bound    = w_tc && (r_dig == DIG_S);
    assign in_ready   = !r_pend_full;
    assign disp_value = r_disp;
    assign seg_n      = r_seg;
    assign an_n       = r_an;
    assign frame_tick = r_tick;
    assign w_hz       = (hundreds == '0);
    assign w_tz       = (tens == '0);

    // Prescaler: per-digit dwell counter, wraps at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pre <= '0;
        else if (w_tc) r_pre <= '0;
        else r_pre <= r_pre + PW'(1);
    end

    // Digit index state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dig <= DIG_U;
        else r_dig <= w_dig_nxt;
    end

    // Digit index advances on terminal count.
    always_comb begin
        w_dig_nxt = r_dig;
        if (w_tc) begin
            unique case (r_dig)
                DIG_U: w_dig_nxt = DIG_T;
                DIG_T: w_dig_nxt = DIG_H;
                DIG_H: w_dig_nxt = DIG_S;
                DIG_S: w_dig_nxt = DIG_U;
            endcase
        end
    end

    // Pending buffer fill and frame-boundary commit; never both at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_disp      <= '0;
        end else if (w_bound && r_pend_full) begin
            r_disp      <= r_pend;
            r_pend_full <= 1'b0;
        end else if (in_valid && !r_pend_full) begin
            r_pend      <= in_data;
            r_pend_full <= 1'b1;
        end
    end

    // Segment/anode selection for the current digit with leading-zero blanking.
    always_comb begin
        w_seg = SEG_BLANK;
        unique case (r_dig)
            DIG_S: w_seg = sign ? SEG_MINUS : SEG_BLANK;
            DIG_H: w_seg = w_hz ? SEG_BLANK : f_seg(hundreds);
            DIG_T: w_seg = (w_hz && w_tz) ? SEG_BLANK : f_seg(tens);
            DIG_U: w_seg = f_seg(units);
        endcase
        w_an = blank ? 4'hF : ~(4'b0001 << r_dig);
    end

    // Registered pin drivers and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg  <= 7'h7F;
            r_an   <= 4'hF;
            r_tick <= 1'b0;
        end else begin
            r_seg  <= w_seg;
            r_an   <= w_an;
            r_tick <= w_bound;
        end
    end

endmodule

// File: doc/c2_display_scan_ctrl.md
# c2_display_scan_ctrl

Sequencer that drives the team's two's-complement-to-decimal converter and time-multiplexes its result onto a 4-digit common-anode seven-segment display (sign, hundreds, tens, units). Accepts new values through a valid/ready handshake with a one-entry pending buffer, and commits them to the converter only at scan-frame boundaries so a frame never shows mixed digits. Sits between the value producer (switches/datapath) and the board display pins.

## Interface
- DW, 8: width of the two's-complement value and of each converter digit output.
- SCAN_DIV, 50000: clock cycles each digit stays enabled; must be >= 2. Prescaler width is $clog2(SCAN_DIV).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DW  two's-complement value to display.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  pending buffer empty; a transfer occurs on a clock edge where in_valid && in_ready.
- blank  in  1  forces all digits off; scanning continues.
- disp_value  out  DW  registered value driven into the converter.
- sign  in  1  converter sign output.
- hundreds, tens, units  in  DW each  converter digit outputs, combinational from disp_value.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active low, registered.
- an_n  out  4  digit enables, active low, registered; bit3 sign, bit2 hundreds, bit1 tens, bit0 units.
- frame_tick  out  1  one-cycle pulse after each frame boundary.

## Operation
- Prescaler counts 0..SCAN_DIV-1 and wraps. Terminal count (TC) advances the digit index dig 0→1→2→3→0.
- Frame boundary = TC while dig==3.
- Pending buffer: on in_valid && in_ready, in_data is stored and pend_full is set. in_ready = !pend_full (combinational).
- At a frame boundary with pend_full: disp_value <= pending, pend_full cleared. With pend_full clear, disp_value holds.
- A handshake on the same edge as the boundary while the buffer is empty loads the buffer only. That value commits at the next boundary.
- Output register, updated every cycle from the current dig and converter outputs:
  - an_n = all ones if blank, else one-cold at dig.
  - dig 3: '-' if sign else blank.
  - dig 2: blank if hundreds==0.
  - dig 1: blank if hundreds==0 && tens==0.
  - dig 0: always shown.
- Any digit value >9 (full-width compare) displays 'E'.
- Encodings (gfedcba, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - '-'=0111111, E=0000110, blank=1111111
- Reset (async, rst_n low):
  - prescaler=0, dig=0, pend_full=0, disp_value=0
  - seg_n=7'h7F, an_n=4'hF, frame_tick=0, in_ready=1
- Reset mid-operation discards the pending value and the current frame. Scanning restarts at dig 0 with a full dwell.

## Timing
- Each digit dwell is exactly SCAN_DIV cycles. A frame is 4*SCAN_DIV cycles.
- seg_n/an_n lag dig and disp_value by 1 cycle (output register). The first post-reset edge shows units of value 0: an_n=1110, seg_n=1000000.
- frame_tick is high for the single cycle following the boundary edge.
- Commit latency: accepted value reaches disp_value at the next boundary edge, and reaches the pins 1 cycle later. Worst case 4*SCAN_DIV+1 cycles.
- in_ready falls the cycle after acceptance and rises the cycle after the commit.
- A blank change reaches an_n one cycle later.

## Test plan
SCAN_DIV=4, DW=8.
- Reset: hold rst_n low → all outputs at reset values. Release → an_n cycles 1110,1101,1011,0111, 4 cycles each; digits 1–3 blank, units shows '0'; frame_tick pulses every 16 cycles.
- Negative value: send 8'h85 (-123) → after the next boundary, frame shows '-'=0111111, '1'=1111001, '2'=0100100, '3'=0110000.
- Minimum value: send 8'h80 → frame shows '-','1','2','8'. Send 8'h07 → sign, hundreds and tens blank; units=1111000.
- Backpressure: send 8'h0A, then hold in_valid with 8'h14 → in_ready stays low until the cycle after the boundary. disp_value goes 0→10, then →20 one frame later; no value is lost or duplicated.
- Blank and reset mid-operation: assert blank mid-frame → an_n=1111 next cycle while frame_tick spacing is unchanged. Pulse rst_n low mid-dwell with the buffer full → pending dropped, disp_value=0, scan restarts at dig 0.
